// File: rtl/crop_pkg.sv
// Shared widths and handshake encodings for the crop-and-buffer pixel path.
package crop_pkg;

    // Bits needed to hold any value 0..n, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_POP  = 2'b01,
        XFER_PUSH = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout is the oldest word whenever empty is low.
module sync_fifo
    import crop_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = occ_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;
    xfer_e            xfer;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign xfer    = xfer_e'({do_push, do_pop});
    assign dout    = mem_q[rd_ptr_q];

    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (xfer)
            XFER_PUSH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            XFER_POP: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            XFER_BOTH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; a stale word is never visible while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/crop_plus_fifo.sv
// Crops a fixed window out of a raster pixel stream and buffers the result in a FIFO.
module crop_plus_fifo
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 40,
    parameter int IN_COLS         = 40,
    parameter int OUT_ROWS        = 20,
    parameter int OUT_COLS        = 20,
    parameter int Y_1             = 10,
    parameter int X_1             = 10,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam int ROW_W = cnt_width(IN_ROWS);
    localparam int COL_W = cnt_width(IN_COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(Y_1);
    localparam logic [COL_W-1:0] COL_LO   = COL_W'(X_1);
    localparam logic [ROW_W-1:0] ROW_SPAN = ROW_W'(OUT_ROWS);
    localparam logic [COL_W-1:0] COL_SPAN = COL_W'(OUT_COLS);

    if ((Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS)) begin : g_bad_window
        $error("crop_plus_fifo: crop window extends past the input frame");
    end

    logic [ROW_W-1:0] row_q, row_d, row_off;
    logic [COL_W-1:0] col_q, col_d, col_off;
    logic             in_window, accept;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Modular offset: positions left of/above the window wrap to values >= span,
    // since the counters are wide enough to hold the full frame dimension.
    assign row_off   = row_q - ROW_LO;
    assign col_off   = col_q - COL_LO;
    assign in_window = (row_off < ROW_SPAN) && (col_off < COL_SPAN);

    assign in_ready  = in_window ? !fifo_full : 1'b1;
    assign accept    = in_valid && in_ready;
    assign fifo_push = accept && in_window;
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    sync_fifo #(
        .WIDTH (PIXEL_BIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pixel_in),
        .dout  (pixel_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_crop_plus_fifo.sv
// Randomised bench for crop_plus_fifo against a frame-index reference model.
module tb_crop_plus_fifo;
    localparam int PW    = 12;
    localparam int IN_R  = 40;
    localparam int IN_C  = 40;
    localparam int WR    = 20;
    localparam int WC    = 20;
    localparam int WY    = 10;
    localparam int WX    = 10;
    localparam int DEPTH = 16;
    localparam int FRAME = IN_R * IN_C;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] pixel_in = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          sel = 1'b0;

    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [PW-1:0] a_pixel_out, b_pixel_out;
    logic          o_in_ready, o_out_valid;
    logic [PW-1:0] o_pixel_out;

    int n_cmp = 0;
    int n_bad = 0;
    int got[$];
    int exp_q[$];
    int ir_bad, hold_bad, acc_at_hold;

    always #5 clk = ~clk;

    crop_plus_fifo #(
        .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IN_R), .IN_COLS(IN_C), .OUT_ROWS(WR),
        .OUT_COLS(WC), .Y_1(WY), .X_1(WX), .FIFO_DEPTH(DEPTH)
    ) u_dut_a (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_ready(a_in_ready), .pixel_out(a_pixel_out), .out_valid(a_out_valid),
        .out_ready(out_ready)
    );

    crop_plus_fifo #(
        .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IN_R), .IN_COLS(IN_C), .OUT_ROWS(IN_R),
        .OUT_COLS(IN_C), .Y_1(0), .X_1(0), .FIFO_DEPTH(DEPTH)
    ) u_dut_b (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_ready(b_in_ready), .pixel_out(b_pixel_out), .out_valid(b_out_valid),
        .out_ready(out_ready)
    );

    assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign o_out_valid = sel ? b_out_valid : a_out_valid;
    assign o_pixel_out = sel ? b_pixel_out : a_pixel_out;

    // Reference: the n-th accepted pixel of a stream sits at frame index n mod FRAME.
    function automatic bit in_win(input int p);
        int q;
        int r;
        int c;
        q = p % FRAME;
        r = q / IN_C;
        c = q % IN_C;
        if (sel) return 1'b1;
        return (r >= WY) && (r < WY + WR) && (c >= WX) && (c < WX + WC);
    endfunction

    function automatic int at(input int i);
        return (i < got.size()) ? got[i] : -1;
    endfunction

    function automatic int seq_diff();
        int d;
        d = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got.size() || got[i] != exp_q[i]) d++;
        end
        return d;
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Streams n_in pixels (value = frame index) and collects outputs until n_out arrive.
    task automatic stream(input int n_in, input int n_out, input int vpct,
                          input int rpct, input int hold, input int budget);
        int  p, cyc, occ, last_pix;
        bit  last_stall, exp_ir;
        got.delete();
        exp_q.delete();
        for (int i = 0; i < n_in; i++) if (in_win(i)) exp_q.push_back(i % FRAME);
        p = 0; cyc = 0; occ = 0; last_pix = 0; last_stall = 1'b0;
        ir_bad = 0; hold_bad = 0; acc_at_hold = -1;
        while (1) begin
            @(negedge clk);
            if (p >= n_in && got.size() >= n_out) break;
            if (cyc >= budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream_timeout: accepted %0d of %0d, outputs %0d of %0d",
                         p, n_in, got.size(), n_out);
                break;
            end
            in_valid  = (p < n_in) && (int'($urandom_range(99)) < vpct);
            pixel_in  = PW'(p % FRAME);
            out_ready = (cyc >= hold) && (int'($urandom_range(99)) < rpct);
            if (cyc == hold) acc_at_hold = p;
            #1;
            exp_ir = !(in_win(p) && occ >= DEPTH);
            if (o_in_ready !== exp_ir) ir_bad++;
            if (last_stall && (o_out_valid !== 1'b1 || int'(o_pixel_out) != last_pix)) hold_bad++;
            last_stall = (o_out_valid === 1'b1) && !out_ready;
            last_pix   = int'(o_pixel_out);
            if (in_valid && o_in_ready === 1'b1) begin
                if (in_win(p)) occ++;
                p++;
            end
            if (o_out_valid === 1'b1 && out_ready) begin
                got.push_back(int'(o_pixel_out));
                occ--;
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset(3);
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_a: got %b want 0", a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_a: got %b want 1", a_in_ready); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_b: got %b want 0", b_out_valid); end
        n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_b: got %b want 1", b_in_ready); end
    endtask

    task automatic test_always_ready();
        int d;
        do_reset(1);
        stream(FRAME, 400, 100, 100, 0, 20000);
        d = seq_diff();
        n_cmp++; if (got.size() != 400) begin n_bad++; $display("FAIL always_count: got %0d want 400", got.size()); end
        n_cmp++; if (at(0) != 410) begin n_bad++; $display("FAIL always_first: got %0d want 410", at(0)); end
        n_cmp++; if (at(19) != 429) begin n_bad++; $display("FAIL always_row_end: got %0d want 429", at(19)); end
        n_cmp++; if (at(20) != 450) begin n_bad++; $display("FAIL always_row_next: got %0d want 450", at(20)); end
        n_cmp++; if (at(399) != 1189) begin n_bad++; $display("FAIL always_last: got %0d want 1189", at(399)); end
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL always_sequence: %0d words differ, want 0", d); end
        n_cmp++; if (ir_bad != 0) begin n_bad++; $display("FAIL always_in_ready: %0d bad cycles, want 0", ir_bad); end
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL always_drained: out_valid %b want 0", o_out_valid); end
    endtask

    task automatic test_random_handshake();
        int d, nonmono;
        do_reset(1);
        stream(FRAME, 400, 60, 50, 0, 20000);
        d = seq_diff();
        nonmono = 0;
        for (int i = 1; i < got.size(); i++) if (got[i] <= got[i-1]) nonmono++;
        n_cmp++; if (got.size() != 400 || d != 0) begin n_bad++; $display("FAIL random_sequence: got %0d words, %0d differ; want 400, 0", got.size(), d); end
        n_cmp++; if (nonmono != 0) begin n_bad++; $display("FAIL random_increasing: %0d non-increasing steps, want 0", nonmono); end
        n_cmp++; if (ir_bad != 0) begin n_bad++; $display("FAIL random_in_ready: %0d bad cycles, want 0", ir_bad); end
        n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL random_hold_stable: %0d unstable cycles, want 0", hold_bad); end
    endtask

    task automatic test_backpressure();
        int d;
        do_reset(1);
        stream(FRAME, 400, 100, 100, 600, 20000);
        d = seq_diff();
        // 410 pixels before the window plus 16 stored pixels can be taken with out_ready held low.
        n_cmp++; if (acc_at_hold != 426) begin n_bad++; $display("FAIL bp_stall_point: accepted %0d want 426", acc_at_hold); end
        n_cmp++; if (ir_bad != 0) begin n_bad++; $display("FAIL bp_in_ready: %0d bad cycles, want 0", ir_bad); end
        n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_hold_stable: %0d unstable cycles, want 0", hold_bad); end
        n_cmp++; if (got.size() != 400 || d != 0) begin n_bad++; $display("FAIL bp_no_loss: got %0d words, %0d differ; want 400, 0", got.size(), d); end
    endtask

    task automatic test_back_to_back();
        int d;
        do_reset(1);
        stream(2 * FRAME, 800, 100, 100, 0, 20000);
        d = seq_diff();
        n_cmp++; if (got.size() != 800) begin n_bad++; $display("FAIL b2b_count: got %0d want 800", got.size()); end
        n_cmp++; if (at(400) != 410) begin n_bad++; $display("FAIL b2b_second_first: got %0d want 410", at(400)); end
        n_cmp++; if (at(799) != 1189) begin n_bad++; $display("FAIL b2b_second_last: got %0d want 1189", at(799)); end
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL b2b_sequence: %0d words differ, want 0", d); end
    endtask

    task automatic test_mid_frame_reset();
        int d;
        do_reset(1);
        stream(500, 0, 100, 30, 0, 20000);
        do_reset(1);
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid: got %b want 0", a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready: got %b want 1", a_in_ready); end
        stream(FRAME, 400, 100, 100, 0, 20000);
        d = seq_diff();
        n_cmp++; if (at(0) != 410) begin n_bad++; $display("FAIL midreset_first: got %0d want 410", at(0)); end
        n_cmp++; if (got.size() != 400 || d != 0) begin n_bad++; $display("FAIL midreset_sequence: got %0d words, %0d differ; want 400, 0", got.size(), d); end
    endtask

    task automatic test_full_window();
        int d;
        sel = 1'b1;
        do_reset(2);
        stream(FRAME, FRAME, 70, 70, 0, 20000);
        d = seq_diff();
        n_cmp++; if (got.size() != FRAME) begin n_bad++; $display("FAIL full_count: got %0d want %0d", got.size(), FRAME); end
        n_cmp++; if (at(FRAME - 1) != FRAME - 1) begin n_bad++; $display("FAIL full_last: got %0d want %0d", at(FRAME - 1), FRAME - 1); end
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL full_sequence: %0d words differ, want 0", d); end
        n_cmp++; if (ir_bad != 0) begin n_bad++; $display("FAIL full_in_ready: %0d bad cycles, want 0", ir_bad); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_always_ready();
        test_random_handshake();
        test_backpressure();
        test_back_to_back();
        test_mid_frame_reset();
        test_full_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
